// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and bit-timing helper
package uart_pkg;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_DATA  = 2'd2;
    localparam uart_state_t ST_STOP  = 2'd3;

    // Used by both transmitter and receiver so the two ends agree on bit length.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchronizer with selectable reset value
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic async_bit,
    output logic sync_bit
);

    logic meta;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            meta     <= RESET_VAL;
            sync_bit <= RESET_VAL;
        end else begin
            meta     <= async_bit;
            sync_bit <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1-style UART receiver with centre-of-bit sampling
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF         = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W        = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_timing
            $error("uart_receiver: CLKS_PER_BIT must be at least 4");
        end
        if (DATA_BITS < 2) begin : g_bad_width
            $error("uart_receiver: DATA_BITS must be at least 2");
        end
    endgenerate

    logic                 s2;
    logic                 s3;
    uart_state_t          state;
    logic [CNT_W-1:0]     clk_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .async_bit (rx_serial),
        .sync_bit  (s2)
    );

    assign rx_busy = (state != ST_IDLE);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            s3           <= 1'b1;
            state        <= ST_IDLE;
            clk_cnt      <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            s3           <= s2;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    // Edge-triggered so a held-low break cannot restart reception.
                    if (!s2 && s3) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= s2 ? ST_IDLE : ST_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt   <= '0;
                        shift_reg <= {s2, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        state   <= ST_IDLE;
                        if (s2) begin
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;

    localparam int CPB  = 10;
    localparam int HALF = CPB / 2;
    localparam int NB   = 8;
    localparam int L    = 2 + HALF + (NB + 1) * CPB;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          rx_serial = 1'b1;
    logic [NB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_frame_err;
    logic          rx_busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0] got_q[$];
    int         got_t[$];
    int         err_t[$];
    int         start_t[$];
    logic [7:0] exp_q[$];
    int         both_cnt = 0;
    int         long_cnt = 0;
    int         busy_rise = -1;
    int         busy_fall = -1;
    logic       v_prev = 1'b0;
    logic       e_prev = 1'b0;
    logic       b_prev = 1'b0;

    uart_receiver #(
        .BAUD_RATE (100_000),
        .CLK_FREQ  (1_000_000),
        .DATA_BITS (NB)
    ) dut (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .rx_serial    (rx_serial),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    always @(negedge PCLK) begin
        if (rx_valid) begin
            got_q.push_back(rx_data);
            got_t.push_back(cyc);
        end
        if (rx_frame_err) err_t.push_back(cyc);
        if (rx_valid && rx_frame_err) both_cnt++;
        if ((rx_valid && v_prev) || (rx_frame_err && e_prev)) long_cnt++;
        if (rx_busy && !b_prev) busy_rise = cyc;
        if (!rx_busy && b_prev) busy_fall = cyc;
        v_prev = rx_valid;
        e_prev = rx_frame_err;
        b_prev = rx_busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        got_t.delete();
        err_t.delete();
        start_t.delete();
        exp_q.delete();
        both_cnt  = 0;
        long_cnt  = 0;
        busy_rise = -1;
        busy_fall = -1;
    endtask

    task automatic drive_bit(input logic b);
        rx_serial = b;
        repeat (CPB) @(posedge PCLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        start_t.push_back(cyc + 1);
        drive_bit(1'b0);
        for (int i = 0; i < NB; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        rx_serial = 1'b1;
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    function automatic logic [7:0] got_at(input int i);
        return (i < got_q.size()) ? got_q[i] : 8'hxx;
    endfunction

    function automatic int got_rel(input int i);
        return (i < got_t.size() && i < start_t.size()) ? got_t[i] - start_t[i] : -1;
    endfunction

    initial begin
        logic [7:0] last_good;
        logic [7:0] r;
        int         s;

        repeat (3) @(posedge PCLK);
        #1;
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_rx_frame_err", 32'(rx_frame_err), 32'h0);
        check("rst_rx_busy", 32'(rx_busy), 32'h0);
        PRESETn = 1'b1;
        idle(5);

        // Single good frame with exact edge timing.
        clear_mon();
        send_frame(8'hA5, 1'b1);
        idle(20);
        check("good_count", 32'(got_q.size()), 32'd1);
        check("good_data", 32'(got_at(0)), 32'hA5);
        check("good_valid_edge", 32'(got_rel(0)), 32'(L));
        check("good_err_count", 32'(err_t.size()), 32'd0);
        check("good_busy_rise", 32'(busy_rise - start_t[0]), 32'd2);
        check("good_busy_fall", 32'(busy_fall - start_t[0]), 32'(L));
        check("good_data_held", 32'(rx_data), 32'hA5);
        check("good_pulse_len", 32'(long_cnt), 32'd0);

        // Back-to-back frames: fixed patterns followed by random bytes.
        clear_mon();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3C);
        for (int i = 0; i < 8; i++) exp_q.push_back(8'($urandom_range(0, 255)));
        foreach (exp_q[i]) send_frame(exp_q[i], 1'b1);
        idle(20);
        check("b2b_count", 32'(got_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            check($sformatf("b2b_data_%0d", i), 32'(got_at(i)), 32'(exp_q[i]));
            check($sformatf("b2b_edge_%0d", i), 32'(got_rel(i)), 32'(L));
        end
        check("b2b_err_count", 32'(err_t.size()), 32'd0);
        check("b2b_both_high", 32'(both_cnt), 32'd0);
        check("b2b_pulse_len", 32'(long_cnt), 32'd0);
        last_good = exp_q[exp_q.size()-1];

        // Three-cycle glitch is rejected at the start-bit sample.
        clear_mon();
        rx_serial = 1'b0;
        s = cyc + 1;
        repeat (3) @(posedge PCLK);
        #1;
        idle(30);
        check("glitch_busy_rise", 32'(busy_rise - s), 32'd2);
        check("glitch_busy_fall", 32'(busy_fall - s), 32'd7);
        check("glitch_valid_count", 32'(got_q.size()), 32'd0);
        check("glitch_err_count", 32'(err_t.size()), 32'd0);

        // Framing error followed by a held-low line.
        clear_mon();
        send_frame(8'h55, 1'b0);
        rx_serial = 1'b0;
        repeat (50) @(posedge PCLK);
        #1;
        check("ferr_count", 32'(err_t.size()), 32'd1);
        check("ferr_edge", 32'((err_t.size() > 0) ? err_t[0] - start_t[0] : -1), 32'(L));
        check("ferr_valid_count", 32'(got_q.size()), 32'd0);
        check("ferr_data_kept", 32'(rx_data), 32'(last_good));
        check("ferr_no_retrigger", 32'(rx_busy), 32'd0);
        check("ferr_both_high", 32'(both_cnt), 32'd0);
        idle(20);
        clear_mon();
        r = 8'($urandom_range(0, 255));
        send_frame(r, 1'b1);
        idle(20);
        check("ferr_recover_count", 32'(got_q.size()), 32'd1);
        check("ferr_recover_data", 32'(got_at(0)), 32'(r));

        // Reset in the middle of data bit 3 of 0x81.
        clear_mon();
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        repeat (5) @(posedge PCLK);
        #2;
        PRESETn = 1'b0;
        #1;
        check("mid_rst_rx_data", 32'(rx_data), 32'h0);
        check("mid_rst_rx_valid", 32'(rx_valid), 32'h0);
        check("mid_rst_rx_frame_err", 32'(rx_frame_err), 32'h0);
        check("mid_rst_rx_busy", 32'(rx_busy), 32'h0);
        rx_serial = 1'b1;
        repeat (5) @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
        idle(20);
        check("mid_rst_no_valid", 32'(got_q.size()), 32'd0);
        check("mid_rst_no_err", 32'(err_t.size()), 32'd0);
        clear_mon();
        send_frame(8'h81, 1'b1);
        idle(20);
        check("post_rst_count", 32'(got_q.size()), 32'd1);
        check("post_rst_data", 32'(got_at(0)), 32'h81);
        check("post_rst_edge", 32'(got_rel(0)), 32'(L));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
